// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at accept time and held in shadow registers until the busy count expires.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [2:0]  md_op,
   input  logic        cancel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   logic [CntW-1:0] r_cnt;
   logic            r_busy;
   logic            r_wr;
   logic [31:0]     r_hi;
   logic [31:0]     r_lo;
   logic [31:0]     r_shadow_hi;
   logic [31:0]     r_shadow_lo;

   logic            w_accept;
   logic            w_sdiv;
   logic [63:0]     w_mul_a;
   logic [63:0]     w_mul_b;
   logic [63:0]     w_prod;
   logic [31:0]     w_div_a;
   logic [31:0]     w_div_b;
   logic [31:0]     w_div_bs;
   logic [31:0]     w_uq;
   logic [31:0]     w_ur;
   logic [31:0]     w_q;
   logic [31:0]     w_r;

   assign w_accept = !cancel && !r_busy;
   assign w_sdiv   = (md_op == OpDiv);

   // Low 64 bits of a sign-extended product equal the signed 32x32 product.
   assign w_mul_a = (md_op == OpMult) ? {{32{A[31]}}, A} : {32'd0, A};
   assign w_mul_b = (md_op == OpMult) ? {{32{B[31]}}, B} : {32'd0, B};
   assign w_prod  = w_mul_a * w_mul_b;

   // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign w_div_a  = (w_sdiv && A[31]) ? (32'd0 - A) : A;
   assign w_div_b  = (w_sdiv && B[31]) ? (32'd0 - B) : B;
   assign w_div_bs = (w_div_b == 32'd0) ? 32'd1 : w_div_b;
   assign w_uq     = w_div_a / w_div_bs;
   assign w_ur     = w_div_a % w_div_bs;
   assign w_q      = (w_sdiv && (A[31] ^ B[31])) ? (32'd0 - w_uq) : w_uq;
   assign w_r      = (w_sdiv && A[31]) ? (32'd0 - w_ur) : w_ur;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_wr        <= 1'b0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_shadow_hi <= '0;
         r_shadow_lo <= '0;
      end else if (r_busy) begin
         r_cnt <= r_cnt - CntW'(1);
         if (r_cnt == CntW'(1)) begin
            r_busy <= 1'b0;
            if (r_wr) begin
               r_hi <= r_shadow_hi;
               r_lo <= r_shadow_lo;
            end
         end
      end else if (w_accept) begin
         case (md_op)
            OpMult, OpMultu: begin
               r_shadow_hi <= w_prod[63:32];
               r_shadow_lo <= w_prod[31:0];
               r_wr        <= 1'b1;
               r_cnt       <= CntW'(MULT_CYCLES);
               r_busy      <= 1'b1;
            end
            OpDiv, OpDivu: begin
               r_shadow_hi <= w_r;
               r_shadow_lo <= w_q;
               r_wr        <= (B != 32'd0);
               r_cnt       <= CntW'(DIV_CYCLES);
               r_busy      <= 1'b1;
            end
            OpMthi:  r_hi <= A;
            OpMtlo:  r_lo <= A;
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: an arithmetic reference model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_md_unit;

   localparam int unsigned MultN = 5;
   localparam int unsigned DivN  = 10;

   logic        clk;
   logic        clr;
   logic [2:0]  md_op;
   logic        cancel;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   md_unit #(
      .MULT_CYCLES(MultN),
      .DIV_CYCLES (DivN)
   ) dut (
      .clk   (clk),
      .clr   (clr),
      .md_op (md_op),
      .cancel(cancel),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remaining busy cycles plus a pending result, updated each edge.
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   bit          m_pvalid;
   int          m_left;

   always @(posedge clk) begin
      longint          sp, sa, sb;
      longint unsigned up;
      if (clr) begin
         m_hi = 0; m_lo = 0; m_left = 0; m_pvalid = 0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0 && m_pvalid) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (!cancel) begin
         sa = longint'($signed(A));
         sb = longint'($signed(B));
         case (md_op)
            3'd1: begin
               sp = sa * sb;
               {m_phi, m_plo} = sp; m_pvalid = 1; m_left = MultN;
            end
            3'd2: begin
               up = longint'(A) * longint'(B);
               {m_phi, m_plo} = up; m_pvalid = 1; m_left = MultN;
            end
            3'd3: begin
               m_pvalid = (B != 0);
               if (m_pvalid) begin
                  m_plo = 32'(sa / sb);
                  m_phi = 32'(sa % sb);
               end
               m_left = DivN;
            end
            3'd4: begin
               m_pvalid = (B != 0);
               if (m_pvalid) begin
                  m_plo = A / B;
                  m_phi = A % B;
               end
               m_left = DivN;
            end
            3'd5: m_hi = A;
            3'd6: m_lo = A;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy", {31'd0, busy}, {31'd0, m_left > 0});
         check("model_hi", HI, m_hi);
         check("model_lo", LO, m_lo);
      end
   end

   // Issue one op, scramble operands, wait for idle; returns at a negedge with busy low.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
      md_op = op; A = a; B = b;
      @(posedge clk);
      #2 md_op = 3'd0; A = $urandom; B = $urandom;
      cycles = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) break;
         cycles++;
      end
      if (busy) begin
         n_checks++; n_fail++;
         $display("FAIL busy_timeout: busy still high after 50 cycles");
      end
   endtask

   int cyc;

   initial begin
      clr = 1'b1; md_op = 3'd0; cancel = 1'b0; A = 0; B = 0;
      repeat (2) @(posedge clk);
      #2 clr = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", HI, 32'd0);
      check("reset_lo", LO, 32'd0);

      // 1. mult -2 * 3
      run_op(3'd1, 32'hFFFFFFFE, 32'd3, cyc);
      check("mult_busy_cycles", cyc, MultN);
      check("mult_hi", HI, 32'hFFFFFFFF);
      check("mult_lo", LO, 32'hFFFFFFFA);

      // 2. multu max*max, issued with no bubble
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
      check("multu_busy_cycles", cyc, MultN);
      check("multu_hi", HI, 32'hFFFFFFFE);
      check("multu_lo", LO, 32'h00000001);

      // 3. div -7/2, then divu by zero leaves HI/LO
      run_op(3'd3, 32'hFFFFFFF9, 32'd2, cyc);
      check("div_busy_cycles", cyc, DivN);
      check("div_lo", LO, 32'hFFFFFFFD);
      check("div_hi", HI, 32'hFFFFFFFF);
      run_op(3'd4, 32'd7, 32'd0, cyc);
      check("divu0_busy_cycles", cyc, DivN);
      check("divu0_lo", LO, 32'hFFFFFFFD);
      check("divu0_hi", HI, 32'hFFFFFFFF);

      // 4. mthi then mtlo back to back
      md_op = 3'd5; A = 32'h12345678;
      @(posedge clk);
      #2 md_op = 3'd6; A = 32'h9ABCDEF0;
      @(negedge clk);
      check("mthi_hi", HI, 32'h12345678);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #2 md_op = 3'd0;
      @(negedge clk);
      check("mtlo_lo", LO, 32'h9ABCDEF0);
      check("mtlo_busy", {31'd0, busy}, 32'd0);

      // 5. clr during cycle 4 of a div
      md_op = 3'd4; A = 32'd100; B = 32'd7;
      @(posedge clk);
      #2 md_op = 3'd0;
      repeat (3) @(posedge clk);
      #2 clr = 1'b1;
      @(posedge clk);
      #2 clr = 1'b0;
      @(negedge clk);
      check("clr_busy", {31'd0, busy}, 32'd0);
      check("clr_hi", HI, 32'd0);
      check("clr_lo", LO, 32'd0);
      repeat (12) @(negedge clk);
      check("clr_no_late_hi", HI, 32'd0);
      check("clr_no_late_lo", LO, 32'd0);

      // 6. cancelled mult, then mthi while busy
      md_op = 3'd5; A = 32'h0000ABCD;
      @(posedge clk);
      #2 md_op = 3'd1; A = 32'd9; B = 32'd9; cancel = 1'b1;
      @(posedge clk);
      #2 md_op = 3'd0; cancel = 1'b0;
      @(negedge clk);
      check("cancel_busy", {31'd0, busy}, 32'd0);
      check("cancel_hi", HI, 32'h0000ABCD);
      check("cancel_lo", LO, 32'd0);
      md_op = 3'd1; A = 32'd6; B = 32'hFFFFFFF9;
      @(posedge clk);
      #2 md_op = 3'd5; A = 32'hDEADBEEF; cancel = 1'b1;
      @(posedge clk);
      #2 cancel = 1'b0;
      @(posedge clk);
      #2 md_op = 3'd0;
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
      @(negedge clk);
      check("busy_mthi_hi", HI, 32'hFFFFFFFF);
      check("busy_mthi_lo", LO, 32'hFFFFFFD6);

      // Extra divide corners
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, cyc);
      check("div_ovf_lo", LO, 32'h80000000);
      check("div_ovf_hi", HI, 32'd0);
      run_op(3'd3, 32'd7, 32'hFFFFFFFE, cyc);
      check("div_negb_lo", LO, 32'hFFFFFFFD);
      check("div_negb_hi", HI, 32'd1);
      run_op(3'd4, 32'hFFFFFFFF, 32'd10, cyc);
      check("divu_lo", LO, 32'h19999999);
      check("divu_hi", HI, 32'd5);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
